game_seq_ctrl: RTL and testbench

- Top-level sequencer for the factorization game. It generates the 4-bit STATE code that the question latch, input counters and 7-seg muxes decode.
- Walks each round through request question -> show question -> player input -> judge -> correct/wrong/timeout -> next round. Tracks score, misses and remaining time.
- Sits between the button/switch front end, the question generator (Q_REQ/QUE_OK), the answer checker (RESULT) and the display/input datapath.

---
 rtl/game_pkg.sv | 26 ++
 rtl/game_tick_timer.sv | 49 ++++
 rtl/game_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_game_seq_ctrl.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the factorization-game sequencer and the input/display datapath:
// state codes, checker verdict codes and the tick-counter width helper.
package game_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0000,
    ST_READY    = 4'b0010,
    ST_QUESTION = 4'b0011,
    ST_INPUT    = 4'b0100,
    ST_JUDGE    = 4'b0101,
    ST_CORRECT  = 4'b0110,
    ST_WRONG    = 4'b0111,
    ST_CLEAR    = 4'b1000,
    ST_TIMEOUT  = 4'b1001,
    ST_GAMEOVER = 4'b1010,
    ST_RESULT   = 4'b1011
  } state_e;

  localparam logic [1:0] RES_PEND = 2'b00;
  localparam logic [1:0] RES_OK   = 2'b01;

  function automatic int tick_cnt_w(input int max_ticks);
    return (max_ticks < 1) ? 1 : $clog2(max_ticks + 1);
  endfunction

endpackage

// File: rtl/game_tick_timer.sv
// Prescaler plus tick down-counter; a load restarts both so a timed state lasts
// exactly value*TICK_CYC cycles from the load.
module game_tick_timer import game_pkg::*; #(
  parameter int TICK_CYC = 50_000_000,
  parameter int CNT_W    = 7
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  input  logic             freeze_i,
  output logic             tick_o,
  output logic             expired_o
);

  localparam int              PRE_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYC - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o    = !freeze_i && (pre_q == PRE_LAST);
  assign expired_o = tick_o && (cnt_q == CNT_W'(1));

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (load_i) begin
      pre_d = '0;
      cnt_d = value_i;
    end else if (tick_o) begin
      pre_d = '0;
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end else if (!freeze_i) begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_seq_ctrl.sv
// Round sequencer for the factorization game: state code, question request, score/miss/time.
// Optional GAME_PAUSE_EN adds a PAUSE level input that freezes timed states.
module game_seq_ctrl import game_pkg::*; #(
  parameter int TICK_CYC    = 50_000_000,
  parameter int SHOW_TICKS  = 3,
  parameter int LIMIT_TICKS = 30,
  parameter int MSG_TICKS   = 2,
  parameter int NUM_Q       = 5,
  parameter int MAX_MISS    = 3
) (
`ifdef GAME_PAUSE_EN
  input  logic       PAUSE,
`endif
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       QUE_OK,
  input  logic       DEC,
  input  logic [1:0] RESULT,
  output logic [3:0] STATE,
  output logic       Q_REQ,
  output logic [3:0] Q_NUM,
  output logic [3:0] SCORE,
  output logic [1:0] MISS,
  output logic [6:0] TIME_LEFT
);

  localparam int         MAX_T0    = (SHOW_TICKS > LIMIT_TICKS) ? SHOW_TICKS : LIMIT_TICKS;
  localparam int         MAX_T     = (MAX_T0 > MSG_TICKS) ? MAX_T0 : MSG_TICKS;
  localparam int         CNT_W     = tick_cnt_w(MAX_T);
  localparam logic [3:0] NUM_Q4    = 4'(NUM_Q);
  localparam logic [1:0] MAX_MISS2 = 2'(MAX_MISS);
  localparam logic [6:0] LIMIT7    = 7'(LIMIT_TICKS);

  function automatic logic [3:0] inc_sat4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [1:0] inc_sat2(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'd1;
  endfunction

  state_e           state_q, state_d;
  logic [3:0]       score_q, score_d, qnum_q, qnum_d;
  logic [1:0]       miss_q, miss_d;
  logic [6:0]       time_q, time_d;
  logic             qreq_q, qreq_d;
  logic             load, tick, expired, paused;
  logic [CNT_W-1:0] tval;

`ifdef GAME_PAUSE_EN
  logic timed_st;
  assign timed_st = state_q inside {ST_QUESTION, ST_INPUT, ST_CORRECT, ST_WRONG,
                                    ST_TIMEOUT, ST_CLEAR, ST_GAMEOVER};
  assign paused   = PAUSE && timed_st;
`else
  assign paused = 1'b0;
`endif

  game_tick_timer #(.TICK_CYC(TICK_CYC), .CNT_W(CNT_W)) u_timer (
    .CLK       (CLK),
    .RST       (RST),
    .load_i    (load),
    .value_i   (tval),
    .freeze_i  (paused),
    .tick_o    (tick),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (START) state_d = ST_READY;
      ST_READY:    if (QUE_OK) state_d = ST_QUESTION;
      ST_QUESTION: if (expired) state_d = ST_INPUT;
      // A DEC on the final tick beats the timeout
      ST_INPUT: begin
        if (DEC && !paused) state_d = ST_JUDGE;
        else if (expired)   state_d = ST_TIMEOUT;
      end
      ST_JUDGE: begin
        if (RESULT == RES_OK)        state_d = ST_CORRECT;
        else if (RESULT != RES_PEND) state_d = ST_WRONG;
      end
      ST_CORRECT:  if (expired) state_d = (qnum_q == NUM_Q4) ? ST_CLEAR : ST_READY;
      ST_WRONG:    if (expired) state_d = (miss_q == MAX_MISS2) ? ST_GAMEOVER : ST_INPUT;
      ST_TIMEOUT: begin
        if (expired) begin
          if (miss_q == MAX_MISS2)    state_d = ST_GAMEOVER;
          else if (qnum_q == NUM_Q4)  state_d = ST_CLEAR;
          else                        state_d = ST_READY;
        end
      end
      ST_CLEAR, ST_GAMEOVER: if (expired) state_d = ST_RESULT;
      ST_RESULT:   if (START) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  assign load = (state_d != state_q);

  // Entry actions: counters update on the edge that enters the state
  always_comb begin
    score_d = score_q;
    miss_d  = miss_q;
    qnum_d  = qnum_q;
    qreq_d  = 1'b0;
    time_d  = '0;
    tval    = '0;
    if (load) begin
      case (state_d)
        ST_READY: begin
          qreq_d = 1'b1;
          if (state_q == ST_IDLE) begin
            score_d = '0;
            miss_d  = '0;
            qnum_d  = '0;
          end
        end
        ST_QUESTION: tval = CNT_W'(SHOW_TICKS);
        ST_INPUT:    tval = CNT_W'(LIMIT_TICKS);
        ST_CORRECT: begin
          tval    = CNT_W'(MSG_TICKS);
          score_d = inc_sat4(score_q);
          qnum_d  = inc_sat4(qnum_q);
        end
        ST_WRONG: begin
          tval   = CNT_W'(MSG_TICKS);
          miss_d = inc_sat2(miss_q);
        end
        ST_TIMEOUT: begin
          tval   = CNT_W'(MSG_TICKS);
          miss_d = inc_sat2(miss_q);
          qnum_d = inc_sat4(qnum_q);
        end
        ST_CLEAR, ST_GAMEOVER: tval = CNT_W'(MSG_TICKS);
        default: ;
      endcase
    end
    if (state_d == ST_INPUT) begin
      if (load)                     time_d = LIMIT7;
      else if (tick && time_q != 0) time_d = time_q - 7'd1;
      else                          time_d = time_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      miss_q  <= '0;
      qnum_q  <= '0;
      time_q  <= '0;
      qreq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      qnum_q  <= qnum_d;
      time_q  <= time_d;
      qreq_q  <= qreq_d;
    end
  end

  assign STATE     = state_q;
  assign Q_REQ     = qreq_q;
  assign Q_NUM     = qnum_q;
  assign SCORE     = score_q;
  assign MISS      = miss_q;
  assign TIME_LEFT = time_q;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Bench for game_seq_ctrl: directed scenarios plus randomized games against a round-level model.
module tb_game_seq_ctrl;

  localparam int TICK = 4, SHOW = 3, LIMIT = 30, MSG = 2, NQ = 2, MM = 3;
  localparam logic [3:0] S_IDLE = 4'b0000, S_READY = 4'b0010, S_QUESTION = 4'b0011,
                         S_INPUT = 4'b0100, S_JUDGE = 4'b0101, S_CORRECT = 4'b0110,
                         S_WRONG = 4'b0111, S_CLEAR = 4'b1000, S_TIMEOUT = 4'b1001,
                         S_GAMEOVER = 4'b1010, S_RESULT = 4'b1011;

  logic       CLK, RST, START, QUE_OK, DEC, Q_REQ;
  logic [1:0] RESULT, MISS;
  logic [3:0] STATE, Q_NUM, SCORE;
  logic [6:0] TIME_LEFT;
`ifdef GAME_PAUSE_EN
  logic       PAUSE;
`endif

  int checks = 0;
  int errors = 0;

  game_seq_ctrl #(.TICK_CYC(TICK), .SHOW_TICKS(SHOW), .LIMIT_TICKS(LIMIT),
                  .MSG_TICKS(MSG), .NUM_Q(NQ), .MAX_MISS(MM)) dut (
`ifdef GAME_PAUSE_EN
    .PAUSE(PAUSE),
`endif
    .CLK(CLK), .RST(RST), .START(START), .QUE_OK(QUE_OK), .DEC(DEC), .RESULT(RESULT),
    .STATE(STATE), .Q_REQ(Q_REQ), .Q_NUM(Q_NUM), .SCORE(SCORE), .MISS(MISS),
    .TIME_LEFT(TIME_LEFT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    step(2);
    RST = 1'b1;
    step(1);
  endtask

  task automatic pulse_start();
    START = 1'b1; step(1); START = 1'b0;
  endtask

  task automatic pulse_dec();
    DEC = 1'b1; step(1); DEC = 1'b0;
  endtask

  task automatic wait_for(input logic [3:0] st, input int budget, output int n);
    n = 0;
    while (STATE !== st && n < budget) begin
      step(1);
      n++;
    end
    if (STATE !== st) n = -1;
  endtask

  task automatic drive_question(input int d);
    int n;
    step(d);
    QUE_OK = 1'b1;
    wait_for(S_QUESTION, 10, n);
    QUE_OK = 1'b0;
    wait_for(S_INPUT, SHOW * TICK + 10, n);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #1 RST = 1'b0;
    START = 1'b1;
    step(2);
    checks++;
    if ({STATE, Q_REQ, Q_NUM, SCORE, MISS, TIME_LEFT} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: STATE=%b Q_REQ=%b Q_NUM=%0d SCORE=%0d MISS=%0d TIME_LEFT=%0d expected all 0",
               STATE, Q_REQ, Q_NUM, SCORE, MISS, TIME_LEFT);
    end
    START = 1'b0;
    RST = 1'b1;
    step(2);
    checks++;
    if (STATE !== S_IDLE) begin
      errors++; $display("FAIL reset_idle: STATE=%b expected %b", STATE, S_IDLE);
    end
  endtask

  task automatic test_question();
    int n, q;
    do_reset();
    pulse_start();
    checks++;
    if (STATE !== S_READY || Q_REQ !== 1'b1) begin
      errors++; $display("FAIL ready_entry: STATE=%b Q_REQ=%b expected %b 1", STATE, Q_REQ, S_READY);
    end
    q = 0;
    repeat (4) begin
      step(1);
      q += int'(Q_REQ);
    end
    checks++;
    if (q != 0 || STATE !== S_READY) begin
      errors++; $display("FAIL q_req_pulse: extra Q_REQ cycles=%0d STATE=%b expected 0 %b", q, STATE, S_READY);
    end
    QUE_OK = 1'b1;
    wait_for(S_QUESTION, 5, n);
    QUE_OK = 1'b0;
    checks++;
    if (n != 1) begin
      errors++; $display("FAIL que_ok_latency: cycles=%0d expected 1", n);
    end
    wait_for(S_INPUT, 40, n);
    checks++;
    if (n != SHOW * TICK) begin
      errors++; $display("FAIL question_len: cycles=%0d expected %0d", n, SHOW * TICK);
    end
    checks++;
    if (TIME_LEFT !== 7'(LIMIT)) begin
      errors++; $display("FAIL time_load: TIME_LEFT=%0d expected %0d", TIME_LEFT, LIMIT);
    end
    step(3);
    checks++;
    if (TIME_LEFT !== 7'(LIMIT)) begin
      errors++; $display("FAIL time_pre_tick: TIME_LEFT=%0d expected %0d", TIME_LEFT, LIMIT);
    end
    step(1);
    checks++;
    if (TIME_LEFT !== 7'(LIMIT - 1)) begin
      errors++; $display("FAIL time_first_tick: TIME_LEFT=%0d expected %0d", TIME_LEFT, LIMIT - 1);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (TIME_LEFT !== 7'd17 && n < 100) begin
      step(1);
      n++;
    end
    checks++;
    if (TIME_LEFT !== 7'd17 || STATE !== S_INPUT) begin
      errors++; $display("FAIL reach_17: TIME_LEFT=%0d STATE=%b expected 17 %b", TIME_LEFT, STATE, S_INPUT);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({STATE, Q_REQ, Q_NUM, SCORE, MISS, TIME_LEFT} !== '0) begin
      errors++;
      $display("FAIL async_reset: STATE=%b Q_NUM=%0d SCORE=%0d MISS=%0d TIME_LEFT=%0d expected all 0",
               STATE, Q_NUM, SCORE, MISS, TIME_LEFT);
    end
    step(1);
    RST = 1'b1;
    step(2);
    checks++;
    if (STATE !== S_IDLE || Q_REQ !== 1'b0) begin
      errors++; $display("FAIL after_reset: STATE=%b Q_REQ=%b expected %b 0", STATE, Q_REQ, S_IDLE);
    end
  endtask

  task automatic test_correct();
    int n;
    do_reset();
    pulse_start();
    for (int r = 1; r <= NQ; r++) begin
      drive_question(r);
      pulse_dec();
      step(3);
      checks++;
      if (STATE !== S_JUDGE) begin
        errors++; $display("FAIL judge_wait: STATE=%b expected %b", STATE, S_JUDGE);
      end
      RESULT = 2'b01; step(1); RESULT = 2'b00;
      checks++;
      if (STATE !== S_CORRECT || SCORE !== 4'(r) || Q_NUM !== 4'(r)) begin
        errors++; $display("FAIL correct_entry: STATE=%b SCORE=%0d Q_NUM=%0d expected %b %0d %0d",
                           STATE, SCORE, Q_NUM, S_CORRECT, r, r);
      end
      if (r < NQ) begin
        wait_for(S_READY, 20, n);
        checks++;
        if (n != MSG * TICK || Q_REQ !== 1'b1) begin
          errors++; $display("FAIL correct_to_ready: cycles=%0d Q_REQ=%b expected %0d 1", n, Q_REQ, MSG * TICK);
        end
      end
    end
    wait_for(S_CLEAR, 20, n);
    checks++;
    if (n != MSG * TICK) begin
      errors++; $display("FAIL correct_to_clear: cycles=%0d expected %0d", n, MSG * TICK);
    end
    wait_for(S_RESULT, 20, n);
    checks++;
    if (n != MSG * TICK) begin
      errors++; $display("FAIL clear_to_result: cycles=%0d expected %0d", n, MSG * TICK);
    end
    step(5);
    checks++;
    if (STATE !== S_RESULT || SCORE !== 4'(NQ)) begin
      errors++; $display("FAIL result_hold: STATE=%b SCORE=%0d expected %b %0d", STATE, SCORE, S_RESULT, NQ);
    end
    pulse_start();
    checks++;
    if (STATE !== S_IDLE) begin
      errors++; $display("FAIL result_to_idle: STATE=%b expected %b", STATE, S_IDLE);
    end
  endtask

  task automatic test_wrong();
    int n;
    do_reset();
    pulse_start();
    drive_question(1);
    pulse_start();
    checks++;
    if (STATE !== S_INPUT) begin
      errors++; $display("FAIL start_ignored: STATE=%b expected %b", STATE, S_INPUT);
    end
    for (int i = 1; i <= MM; i++) begin
      pulse_dec();
      RESULT = (i == 2) ? 2'b11 : 2'b10;
      step(1);
      RESULT = 2'b00;
      checks++;
      if (STATE !== S_WRONG || MISS !== 2'(i) || Q_NUM !== 4'd0) begin
        errors++; $display("FAIL wrong_entry: STATE=%b MISS=%0d Q_NUM=%0d expected %b %0d 0",
                           STATE, MISS, Q_NUM, S_WRONG, i);
      end
      if (i < MM) begin
        wait_for(S_INPUT, 20, n);
        checks++;
        if (n != MSG * TICK || TIME_LEFT !== 7'(LIMIT) || Q_NUM !== 4'd0) begin
          errors++; $display("FAIL wrong_retry: cycles=%0d TIME_LEFT=%0d Q_NUM=%0d expected %0d %0d 0",
                             n, TIME_LEFT, Q_NUM, MSG * TICK, LIMIT);
        end
      end else begin
        wait_for(S_GAMEOVER, 20, n);
        checks++;
        if (n != MSG * TICK || MISS !== 2'(MM)) begin
          errors++; $display("FAIL gameover: cycles=%0d MISS=%0d expected %0d %0d", n, MISS, MSG * TICK, MM);
        end
      end
    end
    wait_for(S_RESULT, 20, n);
    checks++;
    if (n != MSG * TICK) begin
      errors++; $display("FAIL gameover_to_result: cycles=%0d expected %0d", n, MSG * TICK);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    pulse_start();
    drive_question(0);
    wait_for(S_TIMEOUT, 200, n);
    checks++;
    if (n != LIMIT * TICK) begin
      errors++; $display("FAIL timeout_len: cycles=%0d expected %0d", n, LIMIT * TICK);
    end
    checks++;
    if (MISS !== 2'd1 || Q_NUM !== 4'd1 || TIME_LEFT !== 7'd0 || SCORE !== 4'd0) begin
      errors++; $display("FAIL timeout_counts: MISS=%0d Q_NUM=%0d TIME_LEFT=%0d SCORE=%0d expected 1 1 0 0",
                         MISS, Q_NUM, TIME_LEFT, SCORE);
    end
    wait_for(S_READY, 20, n);
    checks++;
    if (n != MSG * TICK || Q_REQ !== 1'b1) begin
      errors++; $display("FAIL timeout_to_ready: cycles=%0d Q_REQ=%b expected %0d 1", n, Q_REQ, MSG * TICK);
    end
  endtask

  task automatic test_dec_final_tick();
    pulse_dec();
    checks++;
    if (STATE !== S_READY) begin
      errors++; $display("FAIL dec_ignored: STATE=%b expected %b", STATE, S_READY);
    end
    drive_question(1);
    step(LIMIT * TICK - 1);
    checks++;
    if (STATE !== S_INPUT || TIME_LEFT !== 7'd1) begin
      errors++; $display("FAIL before_final_tick: STATE=%b TIME_LEFT=%0d expected %b 1", STATE, TIME_LEFT, S_INPUT);
    end
    pulse_dec();
    checks++;
    if (STATE !== S_JUDGE || MISS !== 2'd1) begin
      errors++; $display("FAIL dec_final_tick: STATE=%b MISS=%0d expected %b 1", STATE, MISS, S_JUDGE);
    end
  endtask

`ifdef GAME_PAUSE_EN
  task automatic test_pause();
    int n;
    logic [6:0] tl;
    do_reset();
    pulse_start();
    drive_question(0);
    step(20);
    tl = TIME_LEFT;
    checks++;
    if (tl !== 7'(LIMIT - 20 / TICK)) begin
      errors++; $display("FAIL pause_pre: TIME_LEFT=%0d expected %0d", tl, LIMIT - 20 / TICK);
    end
    PAUSE = 1'b1;
    step(10);
    pulse_dec();
    step(39);
    checks++;
    if (STATE !== S_INPUT || TIME_LEFT !== tl) begin
      errors++; $display("FAIL pause_hold: STATE=%b TIME_LEFT=%0d expected %b %0d", STATE, TIME_LEFT, S_INPUT, tl);
    end
    PAUSE = 1'b0;
    wait_for(S_TIMEOUT, 200, n);
    checks++;
    if (n < 0 || 70 + n != LIMIT * TICK + 50) begin
      errors++; $display("FAIL pause_delay: cycles=%0d expected %0d", 70 + n, LIMIT * TICK + 50);
    end
  endtask
`endif

  task automatic test_random();
    int sc, ms, qn, n, act, rounds;
    logic [3:0] cur, nxt, ent;
    for (int g = 0; g < 5; g++) begin
      do_reset();
      pulse_start();
      sc = 0; ms = 0; qn = 0; cur = S_READY; rounds = 0;
      while ((cur == S_READY || cur == S_INPUT) && rounds < 20) begin
        rounds++;
        if (cur == S_READY) begin
          checks++;
          if (STATE !== S_READY || Q_REQ !== 1'b1) begin
            errors++; $display("FAIL rnd_ready: STATE=%b Q_REQ=%b expected %b 1", STATE, Q_REQ, S_READY);
          end
          drive_question(int'($urandom_range(0, 6)));
        end
        checks++;
        if (STATE !== S_INPUT || TIME_LEFT !== 7'(LIMIT)) begin
          errors++; $display("FAIL rnd_input: STATE=%b TIME_LEFT=%0d expected %b %0d", STATE, TIME_LEFT, S_INPUT, LIMIT);
        end
        act = int'($urandom_range(0, 3));
        if (act == 3) begin
          wait_for(S_TIMEOUT, LIMIT * TICK + 10, n);
          checks++;
          if (n != LIMIT * TICK) begin
            errors++; $display("FAIL rnd_timeout_len: cycles=%0d expected %0d", n, LIMIT * TICK);
          end
          ms = (ms < 3) ? ms + 1 : 3;
          qn = (qn < 15) ? qn + 1 : 15;
          nxt = (ms == MM) ? S_GAMEOVER : (qn == NQ) ? S_CLEAR : S_READY;
        end else begin
          step(int'($urandom_range(0, LIMIT * TICK - 20)));
          pulse_dec();
          step(int'($urandom_range(0, 3)));
          checks++;
          if (STATE !== S_JUDGE) begin
            errors++; $display("FAIL rnd_judge: STATE=%b expected %b", STATE, S_JUDGE);
          end
          RESULT = (act < 2) ? 2'b01 : 2'($urandom_range(2, 3));
          step(1);
          RESULT = 2'b00;
          if (act < 2) begin
            sc = (sc < 15) ? sc + 1 : 15;
            qn = (qn < 15) ? qn + 1 : 15;
            ent = S_CORRECT;
            nxt = (qn == NQ) ? S_CLEAR : S_READY;
          end else begin
            ms = (ms < 3) ? ms + 1 : 3;
            ent = S_WRONG;
            nxt = (ms == MM) ? S_GAMEOVER : S_INPUT;
          end
          checks++;
          if (STATE !== ent) begin
            errors++; $display("FAIL rnd_verdict: STATE=%b expected %b", STATE, ent);
          end
        end
        checks++;
        if (SCORE !== 4'(sc) || MISS !== 2'(ms) || Q_NUM !== 4'(qn)) begin
          errors++; $display("FAIL rnd_counts: SCORE=%0d MISS=%0d Q_NUM=%0d expected %0d %0d %0d",
                             SCORE, MISS, Q_NUM, sc, ms, qn);
        end
        wait_for(nxt, MSG * TICK + 10, n);
        checks++;
        if (n != MSG * TICK) begin
          errors++; $display("FAIL rnd_msg_len: cycles=%0d next=%b expected %0d", n, nxt, MSG * TICK);
        end
        cur = nxt;
      end
      wait_for(S_RESULT, MSG * TICK + 10, n);
      checks++;
      if (n != MSG * TICK || SCORE !== 4'(sc) || MISS !== 2'(ms)) begin
        errors++; $display("FAIL rnd_result: cycles=%0d SCORE=%0d MISS=%0d expected %0d %0d %0d",
                           n, SCORE, MISS, MSG * TICK, sc, ms);
      end
      pulse_start();
      checks++;
      if (STATE !== S_IDLE) begin
        errors++; $display("FAIL rnd_idle: STATE=%b expected %b", STATE, S_IDLE);
      end
    end
  endtask

  initial begin
    START = 1'b0; QUE_OK = 1'b0; DEC = 1'b0; RESULT = 2'b00; RST = 1'b1;
`ifdef GAME_PAUSE_EN
    PAUSE = 1'b0;
`endif
    test_reset();
    test_question();
    test_reset_mid();
    test_correct();
    test_wrong();
    test_timeout();
    test_dec_final_tick();
`ifdef GAME_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
